// File: rtl/icebreaker_mem_arbiter.sv
// Two-phase (ISSUE -> RESP) arbiter sharing the single-port EBR between the Kronos
// instruction and data ports. Optional fairness guard enabled by ARB_STARVE_GUARD_EN.
module icebreaker_mem_arbiter #(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_gnt,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_rd_req,
  input  logic        data_wr_req,
  output logic [31:0] data_rd_data,
  output logic        data_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_en,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rd_data,
  output logic        err_oor
);

  localparam logic       ST_ISSUE  = 1'b0;
  localparam logic       ST_RESP   = 1'b1;
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_INSTR = 2'd1;
  localparam logic [1:0] OWN_DRD   = 2'd2;
  localparam logic [1:0] OWN_DWR   = 2'd3;

  if (MAX_STREAK < 1) begin : g_param_check
    $error("MAX_STREAK must be at least 1");
  end

  logic        state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic        oor_q, oor_d;
  logic        err_q, err_d;
  logic [31:0] instr_hold_q, instr_hold_d;
  logic [31:0] data_hold_q, data_hold_d;

  logic [1:0]  winner;
  logic [31:0] win_addr;
  logic        win_oor;
  logic        force_instr;
  logic        in_resp;
  logic [31:0] resp_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  logic [SW-1:0] streak_q, streak_d;

  assign force_instr = instr_req && (streak_q >= SW'(MAX_STREAK));

  // Streak counts data wins that bypassed a waiting fetch; any fetch win or idle fetch port clears it.
  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_ISSUE) begin
      if ((winner == OWN_INSTR) || !instr_req) begin
        streak_d = '0;
      end else if (((winner == OWN_DRD) || (winner == OWN_DWR)) && (streak_q < SW'(MAX_STREAK))) begin
        streak_d = streak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign force_instr = 1'b0;
`endif

  always_comb begin
    winner = OWN_NONE;
    if (state_q == ST_ISSUE) begin
      if (force_instr) begin
        winner = OWN_INSTR;
      end else if (data_wr_req) begin
        winner = OWN_DWR;
      end else if (data_rd_req) begin
        winner = OWN_DRD;
      end else if (instr_req) begin
        winner = OWN_INSTR;
      end
    end
  end

  assign win_addr = (winner == OWN_INSTR) ? instr_addr : data_addr;
  assign win_oor  = (winner != OWN_NONE) && (win_addr >= MEM_BYTES);

  // Memory strobes are combinational from the ISSUE-phase winner; out-of-range accesses never strobe.
  always_comb begin
    mem_en      = (winner != OWN_NONE) && !win_oor;
    mem_wr_en   = (winner == OWN_DWR) && !win_oor;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_mask = '0;
    if (winner != OWN_NONE) begin
      mem_addr = {win_addr[31:2], 2'b00};
    end
    if (winner == OWN_DWR) begin
      mem_wr_data = data_wr_data;
      mem_wr_mask = data_wr_mask;
    end
  end

  assign in_resp   = (state_q == ST_RESP);
  assign resp_data = oor_q ? '0 : mem_rd_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    oor_d        = oor_q;
    err_d        = err_q;
    instr_hold_d = instr_hold_q;
    data_hold_d  = data_hold_q;
    case (state_q)
      ST_ISSUE: begin
        if (winner != OWN_NONE) begin
          state_d = ST_RESP;
          owner_d = winner;
          oor_d   = win_oor;
          err_d   = err_q | win_oor;
        end
      end
      default: begin
        state_d = ST_ISSUE;
        owner_d = OWN_NONE;
        oor_d   = 1'b0;
        if (owner_q == OWN_INSTR) begin
          instr_hold_d = resp_data;
        end
        if (owner_q == OWN_DRD) begin
          data_hold_d = resp_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_ISSUE;
      owner_q      <= OWN_NONE;
      oor_q        <= 1'b0;
      err_q        <= 1'b0;
      instr_hold_q <= '0;
      data_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      oor_q        <= oor_d;
      err_q        <= err_d;
      instr_hold_q <= instr_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

  // Grants decode straight from state so an async reset during RESP kills them in the same cycle.
  assign instr_gnt    = in_resp && (owner_q == OWN_INSTR);
  assign data_gnt     = in_resp && ((owner_q == OWN_DRD) || (owner_q == OWN_DWR));
  assign instr_data   = instr_gnt ? resp_data : instr_hold_q;
  assign data_rd_data = (in_resp && (owner_q == OWN_DRD)) ? resp_data : data_hold_q;
  assign err_oor      = err_q;

endmodule

// File: tb/tb_icebreaker_mem_arbiter.sv
// Self-checking bench for icebreaker_mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model with a reference memory.
module tb_icebreaker_mem_arbiter;

  localparam int MEM_BYTES  = 4096;
  localparam int MAX_STREAK = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        RSTN;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data;
  logic        instr_gnt;
  logic [31:0] data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_wr_mask;
  logic        data_rd_req;
  logic        data_wr_req;
  logic [31:0] data_rd_data;
  logic        data_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_mask;
  logic        mem_en;
  logic        mem_wr_en;
  logic [31:0] mem_rd_data;
  logic        err_oor;

  icebreaker_mem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .RSTN(RSTN),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(instr_data), .instr_gnt(instr_gnt),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
    .data_rd_req(data_rd_req), .data_wr_req(data_wr_req), .data_rd_data(data_rd_data),
    .data_gnt(data_gnt), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rd_data(mem_rd_data), .err_oor(err_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] phys_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Backing EBR: synchronous read, byte-masked write.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) phys_mem[mem_addr[11:2]] <= merge(phys_mem[mem_addr[11:2]], mem_wr_data, mem_wr_mask);
      else           mem_rd_data <= phys_mem[mem_addr[11:2]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted access occupies the next cycle with its response.
  bit          m_busy;
  int          m_owner;   // 0 none, 1 instr, 2 data read, 3 data write
  logic [31:0] m_addr;
  bit          m_oor;
  int          m_streak;
  logic [31:0] m_ihold, m_dhold;
  bit          m_err;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_addr = '0; m_oor = 0;
    m_streak = 0; m_ihold = '0; m_dhold = '0; m_err = 0;
  endtask

  task automatic model_step();
    int          w;
    logic [31:0] ea;
    logic [31:0] rv;
    bit          o;
    check("err_oor", 32'(err_oor), 32'(m_err));
    if (!m_busy) begin
      w = 0;
      if (GUARD && instr_req && m_streak >= MAX_STREAK) w = 1;
      else if (data_wr_req) w = 3;
      else if (data_rd_req) w = 2;
      else if (instr_req)   w = 1;
      ea = (w == 1) ? instr_addr : data_addr;
      o  = (w != 0) && (ea >= 32'(MEM_BYTES));
      check("issue_mem_en",    32'(mem_en),    32'(w != 0 && !o));
      check("issue_mem_wr_en", 32'(mem_wr_en), 32'(w == 3 && !o));
      check("issue_instr_gnt", 32'(instr_gnt), 32'd0);
      check("issue_data_gnt",  32'(data_gnt),  32'd0);
      check("issue_instr_data", instr_data, m_ihold);
      check("issue_data_rd_data", data_rd_data, m_dhold);
      if (w != 0 && !o) check("issue_mem_addr", mem_addr, {ea[31:2], 2'b00});
      if (w == 3 && !o) begin
        check("issue_mem_wr_data", mem_wr_data, data_wr_data);
        check("issue_mem_wr_mask", 32'(mem_wr_mask), 32'(data_wr_mask));
      end
      if (w != 0) begin
        m_busy = 1; m_owner = w; m_addr = ea; m_oor = o;
        if (o) m_err = 1;
        if (w == 3 && !o) ref_mem[ea[11:2]] = merge(ref_mem[ea[11:2]], data_wr_data, data_wr_mask);
      end
      if (w == 1 || !instr_req) m_streak = 0;
      else if (w >= 2 && m_streak < MAX_STREAK) m_streak++;
    end else begin
      rv = m_oor ? 32'd0 : ref_mem[m_addr[11:2]];
      check("resp_mem_en",    32'(mem_en),    32'd0);
      check("resp_instr_gnt", 32'(instr_gnt), 32'(m_owner == 1));
      check("resp_data_gnt",  32'(data_gnt),  32'(m_owner >= 2));
      if (m_owner == 1) m_ihold = rv;
      if (m_owner == 2) m_dhold = rv;
      check("resp_instr_data",   instr_data,   m_ihold);
      check("resp_data_rd_data", data_rd_data, m_dhold);
      m_busy = 0; m_owner = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!RSTN) model_reset();
      else       model_step();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return 32'h1000 + 32'($urandom_range(0, 4095));
    if ($urandom_range(0, 3) == 0)  return 32'($urandom_range(0, 4095));
    return 32'($urandom_range(0, 255));
  endfunction

  int  cnt_d, dbefore, req_cnt, gnt_cnt;
  bit  got_i, ig, dg, stop_new;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      phys_mem[i] = 32'hC0DE0000 | 32'(i);
      ref_mem[i]  = 32'hC0DE0000 | 32'(i);
    end
    mem_rd_data = '0;
    RSTN = 1'b0;
    instr_addr = '0; instr_req = 1'b0;
    data_addr = '0; data_wr_data = '0; data_wr_mask = '0;
    data_rd_req = 1'b0; data_wr_req = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_gnt", 32'(instr_gnt), 32'd0);
    check("rst_data_gnt",  32'(data_gnt),  32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_err_oor",   32'(err_oor),   32'd0);
    check("rst_mem_addr",  mem_addr,       32'd0);
    check("rst_instr_data", instr_data,    32'd0);
    @(posedge clk); #2 RSTN = 1'b1;

    // Single fetch: strobe in the issue cycle, grant and word one cycle later.
    @(posedge clk); #1 instr_addr = 32'h10; instr_req = 1'b1;
    @(negedge clk);
    check("t1_mem_en",   32'(mem_en), 32'd1);
    check("t1_mem_addr", mem_addr,    32'h10);
    @(negedge clk);
    check("t1_instr_gnt",  32'(instr_gnt), 32'd1);
    check("t1_instr_data", instr_data,     32'hC0DE0004);
    @(posedge clk); #1 instr_req = 1'b0;

    // Simultaneous fetch and masked store: store first, fetch two cycles later.
    @(posedge clk); #1
    instr_addr = 32'h20; instr_req = 1'b1;
    data_addr = 32'h24; data_wr_data = 32'h1234ABCD; data_wr_mask = 4'b0011; data_wr_req = 1'b1;
    @(negedge clk);
    check("t2_mem_wr_en", 32'(mem_wr_en),   32'd1);
    check("t2_mask",      32'(mem_wr_mask), 32'h3);
    check("t2_addr",      mem_addr,         32'h24);
    @(negedge clk);
    check("t2_data_gnt",  32'(data_gnt),  32'd1);
    check("t2_instr_wait", 32'(instr_gnt), 32'd0);
    @(posedge clk); #1 data_wr_req = 1'b0;
    @(negedge clk);
    check("t2_fetch_addr", mem_addr, 32'h20);
    @(negedge clk);
    check("t2_instr_gnt",  32'(instr_gnt), 32'd1);
    check("t2_instr_data", instr_data,     32'hC0DE0008);
    @(posedge clk); #1 instr_req = 1'b0; data_addr = 32'h24; data_rd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_readback_gnt",  32'(data_gnt), 32'd1);
    check("t2_readback_data", data_rd_data,  32'hC0DEABCD);
    @(posedge clk); #1 data_rd_req = 1'b0;

    // Out-of-range load.
    @(posedge clk); #1 data_addr = 32'h1000; data_rd_req = 1'b1;
    @(negedge clk);
    check("t3_mem_en",  32'(mem_en),  32'd0);
    check("t3_err_pre", 32'(err_oor), 32'd0);
    @(negedge clk);
    check("t3_data_gnt",  32'(data_gnt),  32'd1);
    check("t3_data_zero", data_rd_data,   32'd0);
    check("t3_err_oor",   32'(err_oor),   32'd1);
    @(posedge clk); #1 data_rd_req = 1'b0;
    @(negedge clk);
    check("t3_err_sticky", 32'(err_oor), 32'd1);

    // Streaming loads against a waiting fetch.
    @(posedge clk); #1
    data_addr = 32'h40; data_rd_req = 1'b1; instr_addr = 32'h44; instr_req = 1'b1;
    cnt_d = 0; got_i = 0; dbefore = -1;
    for (int c = 0; c < 80 && !(cnt_d >= 10 && got_i); c++) begin
      @(negedge clk);
      if (data_gnt) cnt_d++;
      if (instr_gnt) begin got_i = 1; dbefore = cnt_d; end
      @(posedge clk); #1
      if (cnt_d >= 10) data_rd_req = 1'b0;
      if (got_i) instr_req = 1'b0;
    end
    data_rd_req = 1'b0; instr_req = 1'b0;
    check("t4_instr_granted", 32'(got_i), 32'd1);
    check("t4_data_grants_before_instr", 32'(dbefore), GUARD ? 32'd4 : 32'd10);

    // Reset asserted in the response cycle.
    @(posedge clk); #1 instr_addr = 32'h50; instr_req = 1'b1;
    @(posedge clk); #1
    check("t5_gnt_before", 32'(instr_gnt), 32'd1);
    #1 RSTN = 1'b0;
    #1
    check("t5_gnt_dropped",  32'(instr_gnt), 32'd0);
    check("t5_err_cleared",  32'(err_oor),   32'd0);
    check("t5_data_cleared", instr_data,     32'd0);
    instr_req = 1'b0;
    @(posedge clk); @(posedge clk); #2 RSTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t5_no_stale_gnt", 32'(instr_gnt | data_gnt), 32'd0);
    end

    // Random legal traffic; requests hold until granted.
    req_cnt = 0; gnt_cnt = 0; stop_new = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      stop_new = (cyc >= 800);
      if (stop_new && !instr_req && !data_rd_req && !data_wr_req) break;
      @(negedge clk);
      ig = instr_gnt; dg = data_gnt;
      if (ig) gnt_cnt++;
      if (dg) gnt_cnt++;
      @(posedge clk); #1
      if (instr_req && ig) instr_req = 1'b0;
      if ((data_rd_req || data_wr_req) && dg) begin data_rd_req = 1'b0; data_wr_req = 1'b0; end
      if (!instr_req && !stop_new && $urandom_range(0, 2) == 0) begin
        instr_addr = rand_addr(); instr_req = 1'b1; req_cnt++;
      end
      if (!data_rd_req && !data_wr_req && !stop_new && $urandom_range(0, 1) == 0) begin
        data_addr = rand_addr();
        data_wr_data = $urandom();
        data_wr_mask = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) data_wr_req = 1'b1;
        else                           data_rd_req = 1'b1;
        req_cnt++;
      end
    end
    check("t6_drained", 32'(instr_req | data_rd_req | data_wr_req), 32'd0);
    check("t6_one_gnt_per_req", 32'(gnt_cnt), 32'(req_cnt));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
